iir_mac_accumulator: RTL and testbench

Accumulates a fixed number of signed Q4.26 products from the upstream pipelined multiplier into one IIR output sample. Each frame sums NUM_TERMS products; biquad default is b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2, with coefficient signs applied upstream. The sum is rounded, rescaled to Q2.13 and saturated. The 16-bit result is presented on a valid/ready handshake to the filter's state-update logic.

---
 rtl/iir_mac_accumulator.sv | 141 ++++++++++++++
 tb/tb_iir_mac_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_accumulator.sv
// Sums NUM_TERMS signed Q4.26 products per frame, then rounds, rescales to Q2.13 and saturates.
// The 16-bit result is offered on a valid/ready handshake.
module iir_mac_accumulator #(
  parameter int unsigned NUM_TERMS  = 5,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned FRAC_SHIFT = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] p,
  input  logic               p_valid,
  output logic        [15:0] y,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               busy,
  output logic               sat,
  output logic               drop_err
);

  localparam int unsigned CntW = $clog2(NUM_TERMS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_TERMS - 1);
  localparam logic signed [ACC_W-1:0] RoundK = ACC_W'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] YMax = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] YMin = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {StIdle, StAcc, StRound, StHold} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [15:0]              y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     sat_q, sat_d;
  logic                     drop_q, drop_d;
  logic                     start_frame;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  scaled;

  assign p_ext   = ACC_W'(p);
  assign rounded = acc_q + RoundK;
  // Arithmetic shift after +half gives round-half-up (ties toward +inf).
  assign scaled  = rounded >>> FRAC_SHIFT;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    sat_d       = sat_q;
    drop_d      = drop_q;
    start_frame = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_frame = 1'b1;
        end else if (p_valid) begin
          drop_d = 1'b1;
        end
      end
      StAcc: begin
        if (p_valid) begin
          acc_d = acc_q + p_ext;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StRound;
        end
      end
      StRound: begin
        if (scaled > YMax) begin
          y_d   = 16'h7fff;
          sat_d = 1'b1;
        end else if (scaled < YMin) begin
          y_d   = 16'h8000;
          sat_d = 1'b1;
        end else begin
          y_d   = scaled[15:0];
          sat_d = 1'b0;
        end
        y_valid_d = 1'b1;
        state_d   = StHold;
        if (p_valid) drop_d = 1'b1;
      end
      StHold: begin
        if (y_ready && start) begin
          y_valid_d   = 1'b0;
          start_frame = 1'b1;
        end else begin
          if (y_ready) begin
            y_valid_d = 1'b0;
            state_d   = StIdle;
          end
          if (p_valid) drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Honoured start: a same-cycle product becomes term 0 of the new frame.
    if (start_frame) begin
      drop_d  = 1'b0;
      state_d = StAcc;
      acc_d   = '0;
      cnt_d   = '0;
      if (p_valid) begin
        acc_d = p_ext;
        cnt_d = CntW'(1);
        if (NUM_TERMS == 1) state_d = StRound;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign sat      = sat_q;
  assign drop_err = drop_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_iir_mac_accumulator.sv
// Directed bench for iir_mac_accumulator: a frame-level arithmetic model feeds an expected-result
// queue that a negedge monitor checks whenever y_valid is high, plus literal spot checks.
module tb_iir_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] p = '0;
  logic        p_valid = 1'b0;
  logic [15:0] y;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic        busy;
  logic        sat;
  logic        drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q[$];
  longint      cur_sum;
  int          cur_n;
  bit          in_frame = 1'b0;

  iir_mac_accumulator #(
    .NUM_TERMS (5),
    .ACC_W     (40),
    .FRAC_SHIFT(13)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .p       (p),
    .p_valid (p_valid),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .busy    (busy),
    .sat     (sat),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // {sat, y} from the exact frame sum: round half up, scale by 2^-13, clamp to 16 bits.
  function automatic logic [16:0] model(input longint sum);
    longint s;
    s = (sum + 64'sd4096) >>> 13;
    if (s > 32767) return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input logic [31:0] v);
    if (in_frame) begin
      cur_sum += longint'(signed'(v));
      cur_n++;
      if (cur_n == 5) begin
        exp_q.push_back(model(cur_sum));
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic model_new_frame();
    in_frame = 1'b1;
    cur_sum  = 0;
    cur_n    = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    model_new_frame();
    tick();
    start = 1'b0;
  endtask

  // Product with the multiplier's one-per-three-cycles cadence.
  task automatic do_p(input logic [31:0] v);
    p       = v;
    p_valid = 1'b1;
    model_add(v);
    tick();
    p_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frame(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input logic [31:0] v4);
    do_start();
    do_p(v0);
    do_p(v1);
    do_p(v2);
    do_p(v3);
    do_p(v4);
  endtask

  // Monitor: every cycle with y_valid high, the presented result must match the queue head.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_unexpected: got y_valid=1 y=0x%0h, expected no result", y);
      end else begin
        chk("mon_y", {16'h0, y}, {16'h0, exp_q[0][15:0]});
        chk("mon_sat", {31'h0, sat}, {31'h0, exp_q[0][16]});
        if (y_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int waited;

    // Model pins against hand-computed results.
    chk("model_nominal", {15'h0, model(5 * 64'sh0100_0000)}, {15'h0, 1'b0, 16'h2800});
    chk("model_tie_pos", {15'h0, model(64'sd4096)}, {15'h0, 1'b0, 16'h0001});
    chk("model_neg", {15'h0, model(-64'sd4097)}, {15'h0, 1'b0, 16'hffff});
    chk("model_sat_lo", {15'h0, model(-5 * 64'sh8000_0000)}, {15'h0, 1'b1, 16'h8000});

    // Reset state.
    #2;
    chk("rst_y", {16'h0, y}, 32'h0);
    chk("rst_y_valid", {31'h0, y_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_sat", {31'h0, sat}, 32'h0);
    chk("rst_drop", {31'h0, drop_err}, 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Nominal frame with latency: y_valid exactly 2 edges after the 5th product, one cycle wide.
    do_start();
    for (int i = 0; i < 4; i++) do_p(32'h0100_0000);
    p = 32'h0100_0000;
    p_valid = 1'b1;
    model_add(p);
    tick();
    p_valid = 1'b0;
    chk("lat_k_valid", {31'h0, y_valid}, 32'h0);
    chk("lat_k_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("lat_k1_valid", {31'h0, y_valid}, 32'h1);
    chk("nom_y", {16'h0, y}, 32'h2800);
    chk("nom_sat", {31'h0, sat}, 32'h0);
    tick();
    chk("lat_k2_valid", {31'h0, y_valid}, 32'h0);
    chk("lat_k2_busy", {31'h0, busy}, 32'h0);
    chk("hold_y_after_accept", {16'h0, y}, 32'h2800);

    // Rounding boundaries.
    run_frame(0, 0, 0, 0, 32'h0000_1000);
    chk("rnd_half_up", {16'h0, y}, 32'h0001);
    run_frame(0, 0, 0, 0, 32'h0000_0fff);
    chk("rnd_below_half", {16'h0, y}, 32'h0000);
    run_frame(0, 0, 0, 0, 32'hffff_efff);
    chk("rnd_neg_below", {16'h0, y}, 32'hffff);
    run_frame(0, 0, 0, 0, 32'hffff_f000);
    chk("rnd_neg_tie", {16'h0, y}, 32'h0000);
    chk("rnd_sat_clear", {31'h0, sat}, 32'h0);

    // Saturation both ways.
    run_frame(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    chk("sat_hi_y", {16'h0, y}, 32'h7fff);
    chk("sat_hi_flag", {31'h0, sat}, 32'h1);
    run_frame(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    chk("sat_lo_y", {16'h0, y}, 32'h8000);
    chk("sat_lo_flag", {31'h0, sat}, 32'h1);

    // Backpressure, drop in HOLD, then accept-with-start back to back.
    y_ready = 1'b0;
    run_frame(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    waited = 0;
    while (!y_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("bp_valid_seen", {31'h0, y_valid}, 32'h1);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_valid_held", {31'h0, y_valid}, 32'h1);
    chk("bp_y_held", {16'h0, y}, 32'h2800);
    p = 32'h1234_5678;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    chk("hold_drop_set", {31'h0, drop_err}, 32'h1);
    chk("hold_drop_y", {16'h0, y}, 32'h2800);
    y_ready = 1'b1;
    start = 1'b1;
    model_new_frame();
    tick();
    start = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 32'h1);
    chk("b2b_drop_clr", {31'h0, drop_err}, 32'h0);
    chk("b2b_valid_low", {31'h0, y_valid}, 32'h0);
    for (int i = 0; i < 5; i++) do_p(32'h0200_0000);
    chk("b2b_y", {16'h0, y}, 32'h5000);

    // Drop in IDLE, then start/product collision with ignored starts during ACC.
    p = 32'h0000_0001;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    chk("idle_drop_set", {31'h0, drop_err}, 32'h1);
    chk("idle_drop_busy", {31'h0, busy}, 32'h0);
    start = 1'b1;
    p = 32'h0100_0000;
    p_valid = 1'b1;
    model_new_frame();
    model_add(p);
    tick();
    start = 1'b0;
    p_valid = 1'b0;
    chk("coll_drop_clr", {31'h0, drop_err}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      do_p(32'h0100_0000);
    end
    chk("coll_y", {16'h0, y}, 32'h2800);
    chk("coll_idle", {31'h0, busy}, 32'h0);

    // Reset mid-frame, then a clean frame with no residue.
    do_start();
    do_p(32'h0100_0000);
    do_p(32'h0100_0000);
    do_p(32'h0100_0000);
    in_frame = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", {16'h0, y}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_valid", {31'h0, y_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);
    chk("post_rst_y", {16'h0, y}, 32'h1400);
    chk("post_rst_sat", {31'h0, sat}, 32'h0);

    tick();
    tick();
    chk("all_results_seen", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
